// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory loader.
//   - loader_state_e  : loader FSM state encoding
//   - COUNT_HDR_BYTES : number of bytes in the word-count header
//   - LOAD_END_STATE  : state entered once the last word has been taken
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHECK state, which
// validates a trailing XOR checksum byte before declaring success.
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int COUNT_HDR_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
`ifdef LOADER_CHECKSUM_EN
    ,
    CHECK   = 3'd7
`endif
  } loader_state_e;

  // Where the stream goes once all payload words (or a zero count) are seen.
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e LOAD_END_STATE = CHECK;
`else
  localparam loader_state_e LOAD_END_STATE = DONE;
`endif

endpackage

// File: rtl/inst_mem_loader_byte_pair_assembler.sv
// ---------------------------------------------------------------------------
// byte_pair_assembler
// Pairs a high byte and a low byte into one 16-bit word and flags it valid
// for exactly one cycle after the low byte is taken.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   byteIn       : incoming serial byte
//   hiLoad       : capture byteIn as the high half
//   loLoad       : byteIn is the low half; register the completed word
//   word         : last completed word (held until the next one)
//   wordValid    : one-cycle pulse, high the cycle after loLoad
// ---------------------------------------------------------------------------
module byte_pair_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byteIn,
  input  logic        hiLoad,
  input  logic        loLoad,
  output logic [15:0] word,
  output logic        wordValid
);

  logic [7:0] high_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      high_byte <= 8'h00;
      word      <= 16'h0000;
      wordValid <= 1'b0;
    end else begin
      wordValid <= loLoad;
      if (hiLoad) high_byte <= byteIn;
      if (loLoad) word <= {high_byte, byteIn};
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
// Receives a byte stream (count high, count low, then N words high byte
// first) and writes the words into instruction memory starting at
// BASE_ADDR, holding the CPU in reset for the duration of the load.
// Parameters:
//   MEM_DEPTH : number of 16-bit words the instruction memory can hold
//   BASE_ADDR : address of the first loaded word
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   start                 : single-cycle load request (IDLE/DONE/ERROR only)
//   byteIn/byteValid      : serial byte source
//   byteReady             : loader takes byteIn on this cycle's edge
//   memAddr/memData/memWe : instruction-memory write port
//   cpuHold               : keeps the CPU in reset while loading
//   done/error            : sticky outcome of the last load
//   wordsLoaded           : words written in the current/last load
// Optional feature macro: LOADER_CHECKSUM_EN appends a CHECK state that
// compares one trailing byte with the XOR of all preceding stream bytes.
// ---------------------------------------------------------------------------
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [15:0] memAddr,
  output logic [15:0] memData,
  output logic        memWe,
  output logic        cpuHold,
  output logic        done,
  output logic        error,
  output logic [15:0] wordsLoaded
);

  localparam int          HDR_BITS    = COUNT_HDR_BYTES * 8;
  localparam logic [31:0] DEPTH_LIMIT = 32'(MEM_DEPTH);

  loader_state_e state, state_next;

  logic [HDR_BITS-9:0] count_hi;
  logic [HDR_BITS-1:0] count_value;
  logic [15:0]         word_count;
  logic                hi_load;
  logic                lo_load;
  logic                accept_start;
  logic                last_word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  // The count is only complete while the low byte is on byteIn.
  assign count_value = {count_hi, byteIn};
  assign last_word   = (wordsLoaded + 16'd1) == word_count;

  // CPU stays held in every byte-accepting state, and also through the
  // write pulse of the final word, which lands after the FSM has moved on.
  assign cpuHold = byteReady | memWe;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    byteReady    = 1'b0;
    hi_load      = 1'b0;
    lo_load      = 1'b0;
    accept_start = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          accept_start = 1'b1;
          state_next   = CNT_HI;
        end
      end
      CNT_HI: begin
        byteReady = 1'b1;
        if (byteValid) state_next = CNT_LO;
      end
      CNT_LO: begin
        byteReady = 1'b1;
        if (byteValid) begin
          if ({16'd0, count_value} > DEPTH_LIMIT) state_next = ERROR;
          else if (count_value == 16'd0)          state_next = LOAD_END_STATE;
          else                                    state_next = DATA_HI;
        end
      end
      DATA_HI: begin
        byteReady = 1'b1;
        if (byteValid) begin
          hi_load    = 1'b1;
          state_next = DATA_LO;
        end
      end
      DATA_LO: begin
        byteReady = 1'b1;
        if (byteValid) begin
          lo_load    = 1'b1;
          state_next = last_word ? LOAD_END_STATE : DATA_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        byteReady = 1'b1;
        if (byteValid) state_next = (byteIn == checksum) ? DONE : ERROR;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: header capture, write address/count, and sticky flags.
  // The address uses the pre-increment count so word k lands at BASE_ADDR+k.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_hi    <= '0;
      word_count  <= 16'h0000;
      wordsLoaded <= 16'h0000;
      memAddr     <= 16'h0000;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum    <= 8'h00;
`endif
    end else begin
      if (accept_start) begin
        wordsLoaded <= 16'h0000;
        done        <= 1'b0;
        error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        checksum    <= 8'h00;
`endif
      end else begin
        if (state_next == DONE && state != DONE)   done  <= 1'b1;
        if (state_next == ERROR && state != ERROR) error <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (byteReady && byteValid) checksum <= checksum ^ byteIn;
`endif
      end
      if (state == CNT_HI && byteValid) count_hi <= byteIn;
      if (state == CNT_LO && byteValid) word_count <= count_value;
      if (lo_load) begin
        memAddr     <= BASE_ADDR + wordsLoaded;
        wordsLoaded <= wordsLoaded + 16'd1;
      end
    end
  end

  byte_pair_assembler u_pair (
    .clock     (clock),
    .reset     (reset),
    .byteIn    (byteIn),
    .hiLoad    (hi_load),
    .loLoad    (lo_load),
    .word      (memData),
    .wordValid (memWe)
  );

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
// Directed and randomized loads of inst_mem_loader. Expected writes and
// flags come from a stream-level model that reads the byte list directly.
// Optional feature macro: LOADER_CHECKSUM_EN (must match the RTL build).
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;
  import loader_pkg::*;

  localparam int          MEM_DEPTH = 256;
  localparam logic [15:0] BASE_ADDR = 16'h0000;

  typedef logic [7:0] stream_t[$];
  typedef struct packed {
    logic        hold;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        byteReady;
  logic [15:0] memAddr;
  logic [15:0] memData;
  logic        memWe;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [15:0] wordsLoaded;

  int  checks = 0;
  int  errors = 0;
  wr_t seen[$];

  always #5 clock = ~clock;

  inst_mem_loader #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .byteIn      (byteIn),
    .byteValid   (byteValid),
    .byteReady   (byteReady),
    .memAddr     (memAddr),
    .memData     (memData),
    .memWe       (memWe),
    .cpuHold     (cpuHold),
    .done        (done),
    .error       (error),
    .wordsLoaded (wordsLoaded)
  );

  // Record every memory write together with the CPU hold seen alongside it.
  always @(negedge clock) begin
    if (memWe === 1'b1) begin
      wr_t w;
      w.hold = cpuHold;
      w.addr = memAddr;
      w.data = memData;
      seen.push_back(w);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Stream-level reference: count header, payload words, optional checksum.
  task automatic modelStream(input stream_t s, output wr_t expWr[$],
                             output bit expDone, output bit expError,
                             output int expWords);
    int  n;
    wr_t w;
    n        = {s[0], s[1]};
    expWr    = {};
    expDone  = 1'b0;
    expError = 1'b0;
    expWords = 0;
    if (n > MEM_DEPTH) begin
      expError = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        w.hold = 1'b1;
        w.addr = BASE_ADDR + 16'(k);
        w.data = {s[2 + 2 * k], s[3 + 2 * k]};
        expWr.push_back(w);
      end
      expWords = n;
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] x = 8'h00;
        for (int k = 0; k < 2 + 2 * n; k++) x ^= s[k];
        if (s[2 + 2 * n] == x) expDone = 1'b1;
        else                   expError = 1'b1;
      end
`else
      expDone = 1'b1;
`endif
    end
  endtask

  task automatic addChecksum(inout stream_t s);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (s[k]) x ^= s[k];
    s.push_back(x);
`endif
  endtask

  task automatic makeLoad(input int n, output stream_t s);
    logic [15:0] nn = 16'(n);
    s = {};
    s.push_back(nn[15:8]);
    s.push_back(nn[7:0]);
    for (int k = 0; k < 2 * n; k++) s.push_back(8'($urandom_range(0, 255)));
    addChecksum(s);
  endtask

  // Present each byte until the loader takes it, optionally with random gaps.
  task automatic applyStimulus(input stream_t s, input bit randomValid);
    for (int i = 0; i < s.size(); i++) begin
      int budget = 0;
      bit sent   = 1'b0;
      while (!sent && budget < 64) begin
        byteIn    = s[i];
        byteValid = randomValid ? 1'($urandom_range(0, 1)) : 1'b1;
        sent      = byteValid && (byteReady === 1'b1);
        @(negedge clock);
        budget++;
      end
      checkOutput($sformatf("byte%0d accepted", i), 64'(sent), 64'd1);
      if (!sent) break;
    end
    byteValid = 1'b0;
  endtask

  task automatic runLoad(input string name, input stream_t s, input bit randomValid);
    wr_t expWr[$];
    bit  expDone, expError;
    int  expWords;
    modelStream(s, expWr, expDone, expError, expWords);
    seen.delete();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    checkOutput({name, " start clears"}, {done, error, wordsLoaded}, 64'd0);
    applyStimulus(s, randomValid);
    repeat (4) @(negedge clock);
    #1;
    checkOutput({name, " write count"}, 64'(seen.size()), 64'(expWr.size()));
    for (int k = 0; k < expWr.size() && k < seen.size(); k++)
      checkOutput($sformatf("%s write%0d", name, k), 64'(seen[k]), 64'(expWr[k]));
    checkOutput({name, " done"},        64'(done),        64'(expDone));
    checkOutput({name, " error"},       64'(error),       64'(expError));
    checkOutput({name, " wordsLoaded"}, 64'(wordsLoaded), 64'(expWords));
    checkOutput({name, " idle outs"},   {cpuHold, byteReady, memWe}, 64'd0);
  endtask

  initial begin
    stream_t s;
    stream_t part;
    $display("[TB] starting inst_mem_loader bench");
    reset     = 1'b1;
    start     = 1'b0;
    byteIn    = 8'h00;
    byteValid = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset flags",  {done, error, wordsLoaded}, 64'd0);
    checkOutput("reset mem",    {memWe, memAddr, memData}, 64'd0);
    checkOutput("reset hold",   {cpuHold, byteReady}, 64'd0);
    checkOutput("reset state",  64'(dut.state), 64'(IDLE));
    reset = 1'b0;

    // Two-word reference load.
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    addChecksum(s);
    runLoad("two words", s, 1'b0);

    // Empty load.
    s = '{8'h00, 8'h00};
    addChecksum(s);
    runLoad("zero count", s, 1'b0);

    // Count just above the memory depth.
    s = '{8'h01, 8'h01};
    runLoad("oversize", s, 1'b0);

    // Three words with a throttled source.
    makeLoad(3, s);
    runLoad("three words gaps", s, 1'b1);

    // Randomized lengths, a random oversize count, and the exact-depth boundary.
    for (int t = 0; t < 4; t++) begin
      makeLoad($urandom_range(1, 6), s);
      runLoad($sformatf("random%0d", t), s, 1'b1);
    end
    begin
      logic [15:0] big = 16'($urandom_range(MEM_DEPTH + 1, 65535));
      s = {};
      s.push_back(big[15:8]);
      s.push_back(big[7:0]);
      runLoad("random oversize", s, 1'b0);
    end
    makeLoad(MEM_DEPTH, s);
    runLoad("full depth", s, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    runLoad("checksum good", s, 1'b0);
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    runLoad("checksum bad", s, 1'b0);
`endif

    // Reset landing on the edge that would take the second word's low byte.
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    part = {};
    for (int k = 0; k < 5; k++) part.push_back(s[k]);
    seen.delete();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    applyStimulus(part, 1'b0);
    checkOutput("abort ready before", 64'(byteReady), 64'd1);
    byteIn    = s[5];
    byteValid = 1'b1;
    reset     = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("abort memWe",  64'(memWe), 64'd0);
    checkOutput("abort state",  64'(dut.state), 64'(IDLE));
    checkOutput("abort mem",    {memAddr, memData}, 64'd0);
    checkOutput("abort flags",  {cpuHold, byteReady, done, error, wordsLoaded}, 64'd0);
    byteValid = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("abort after memWe", 64'(memWe), 64'd0);
    checkOutput("abort write count", 64'(seen.size()), 64'd1);
    if (seen.size() > 0)
      checkOutput("abort first write", 64'(seen[0]), {31'd0, 1'b1, 16'h0000, 16'h1234});

    // Loader must be usable again after the abort.
    makeLoad(2, s);
    runLoad("after abort", s, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
